// File: rtl/cu_pkg.sv
// Shared state, opcode and control-word definitions for the multi-cycle control unit.
package cu_pkg;

    typedef enum logic [2:0] {
        StInit,
        StFetchL,
        StFetchH,
        StExec,
        StExec2,
        StHalt
    } state_e;

    localparam logic [3:0] OpLdi  = 4'h0;
    localparam logic [3:0] OpLdm  = 4'h1;
    localparam logic [3:0] OpStm  = 4'h2;
    localparam logic [3:0] OpMov  = 4'h3;
    localparam logic [3:0] OpAnd  = 4'h4;
    localparam logic [3:0] OpOr   = 4'h5;
    localparam logic [3:0] OpAdd  = 4'h6;
    localparam logic [3:0] OpSub  = 4'h7;
    localparam logic [3:0] OpNot  = 4'h8;
    localparam logic [3:0] OpBra  = 4'h9;
    localparam logic [3:0] OpBne  = 4'hA;
    localparam logic [3:0] OpInc  = 4'hB;
    localparam logic [3:0] OpDec  = 4'hC;
    localparam logic [3:0] OpLdar = 4'hD;
    localparam logic [3:0] OpAddm = 4'hE;
    localparam logic [3:0] OpHalt = 4'hF;

    localparam logic [1:0] FunDec   = 2'b00;
    localparam logic [1:0] FunInc   = 2'b01;
    localparam logic [1:0] FunLoad  = 2'b10;
    localparam logic [1:0] FunClear = 2'b11;

    localparam logic [1:0] ArfOutPc = 2'b00;
    localparam logic [1:0] ArfOutAr = 2'b10;
    localparam logic [1:0] ArfOutSp = 2'b11;

    localparam logic [2:0] ArfSelPc  = 3'b100;
    localparam logic [2:0] ArfSelAr  = 3'b010;
    localparam logic [2:0] ArfSelAll = 3'b111;

    localparam logic [1:0] MuxAluOut = 2'b00;
    localparam logic [1:0] MuxMemOut = 2'b01;
    localparam logic [1:0] MuxIrImm  = 2'b10;
    localparam logic [1:0] MuxArfC   = 2'b11;

    localparam logic       MuxCRfA = 1'b0;

    localparam logic [3:0] AluPassA = 4'b0000;
    localparam logic [3:0] AluNot   = 4'b0010;
    localparam logic [3:0] AluAdd   = 4'b0100;
    localparam logic [3:0] AluSub   = 4'b0110;
    localparam logic [3:0] AluAnd   = 4'b0111;
    localparam logic [3:0] AluOr    = 4'b1000;

    localparam int unsigned FlagZ = 3;

    typedef struct packed {
        logic [1:0] rf_out_a_sel;
        logic [1:0] rf_out_b_sel;
        logic [1:0] rf_fun_sel;
        logic [3:0] rf_reg_sel;
        logic [3:0] alu_fun_sel;
        logic [1:0] arf_out_c_sel;
        logic [1:0] arf_out_d_sel;
        logic [1:0] arf_fun_sel;
        logic [2:0] arf_reg_sel;
        logic       ir_lh;
        logic       ir_enable;
        logic [1:0] ir_funsel;
        logic       mem_wr;
        logic       mem_cs;
        logic [1:0] mux_a_sel;
        logic [1:0] mux_b_sel;
        logic       mux_c_sel;
        logic       halted;
    } ctrl_t;

    // Nothing written, memory deselected.
    function automatic ctrl_t ctrl_idle();
        ctrl_t c;
        c        = '0;
        c.mem_cs = 1'b1;
        return c;
    endfunction

    // Register field 0..3 addresses R1..R4, i.e. RF_RegSel bit 0..3.
    function automatic logic [3:0] rf_sel(input logic [1:0] r);
        return 4'b0001 << r;
    endfunction

    function automatic logic [3:0] alu_for_op(input logic [3:0] op);
        logic [3:0] f;
        case (op)
            OpAnd:   f = AluAnd;
            OpOr:    f = AluOr;
            OpAdd:   f = AluAdd;
            OpSub:   f = AluSub;
            OpNot:   f = AluNot;
            default: f = AluPassA;
        endcase
        return f;
    endfunction

endpackage

// File: rtl/cu_decode.sv
// Combinational decoder: state + instruction + flags -> control word and next state.
module cu_decode
    import cu_pkg::*;
(
    input  state_e      state_i,
    input  logic        reset_i,
    input  logic [15:0] ir_i,
    input  logic [3:0]  flag_i,
    output ctrl_t       ctrl_o,
    output state_e      state_d_o
);

    logic [3:0] opcode;
    logic [1:0] rd;
    logic [1:0] rs1;
    logic [1:0] rs2;
    logic       unused_bits;

    assign opcode      = ir_i[15:12];
    assign rd          = ir_i[11:10];
    assign rs1         = ir_i[9:8];
    assign rs2         = ir_i[7:6];
    assign unused_bits = ^{ir_i[5:0], flag_i[2:0]};

    always_comb begin
        ctrl_o    = ctrl_idle();
        state_d_o = StInit;

        case (state_i)
            StInit: begin
                ctrl_o.rf_reg_sel  = 4'b1111;
                ctrl_o.rf_fun_sel  = FunClear;
                ctrl_o.arf_reg_sel = ArfSelAll;
                ctrl_o.arf_fun_sel = FunClear;
                state_d_o          = StFetchL;
            end

            StFetchL, StFetchH: begin
                ctrl_o.arf_out_d_sel = ArfOutPc;
                ctrl_o.mem_cs        = 1'b0;
                ctrl_o.mem_wr        = 1'b0;
                ctrl_o.ir_enable     = 1'b1;
                ctrl_o.ir_lh         = (state_i == StFetchH);
                ctrl_o.ir_funsel     = FunLoad;
                ctrl_o.arf_reg_sel   = ArfSelPc;
                ctrl_o.arf_fun_sel   = FunInc;
                state_d_o            = (state_i == StFetchL) ? StFetchH : StExec;
            end

            StExec: begin
                state_d_o = StFetchL;
                case (opcode)
                    OpLdi: begin
                        ctrl_o.mux_a_sel  = MuxIrImm;
                        ctrl_o.rf_fun_sel = FunLoad;
                        ctrl_o.rf_reg_sel = rf_sel(rd);
                    end
                    // ADDM's first cycle is an LDM; the add happens in EXEC2.
                    OpLdm, OpAddm: begin
                        ctrl_o.arf_out_d_sel = ArfOutAr;
                        ctrl_o.mem_cs        = 1'b0;
                        ctrl_o.mux_a_sel     = MuxMemOut;
                        ctrl_o.rf_fun_sel    = FunLoad;
                        ctrl_o.rf_reg_sel    = rf_sel(rd);
                        if (opcode == OpAddm) begin
                            state_d_o = StExec2;
                        end
                    end
                    OpStm: begin
                        ctrl_o.arf_out_d_sel = ArfOutAr;
                        ctrl_o.rf_out_a_sel  = rd;
                        ctrl_o.mux_c_sel     = MuxCRfA;
                        ctrl_o.alu_fun_sel   = AluPassA;
                        ctrl_o.mem_cs        = 1'b0;
                        ctrl_o.mem_wr        = 1'b1;
                    end
                    OpMov, OpAnd, OpOr, OpAdd, OpSub, OpNot: begin
                        ctrl_o.rf_out_a_sel = rs1;
                        ctrl_o.rf_out_b_sel = rs2;
                        ctrl_o.mux_c_sel    = MuxCRfA;
                        ctrl_o.alu_fun_sel  = alu_for_op(opcode);
                        ctrl_o.mux_a_sel    = MuxAluOut;
                        ctrl_o.rf_fun_sel   = FunLoad;
                        ctrl_o.rf_reg_sel   = rf_sel(rd);
                    end
                    OpBra, OpBne: begin
                        if (opcode == OpBra || !flag_i[FlagZ]) begin
                            ctrl_o.mux_b_sel   = MuxIrImm;
                            ctrl_o.arf_reg_sel = ArfSelPc;
                            ctrl_o.arf_fun_sel = FunLoad;
                        end
                    end
                    OpInc, OpDec: begin
                        ctrl_o.rf_fun_sel = (opcode == OpInc) ? FunInc : FunDec;
                        ctrl_o.rf_reg_sel = rf_sel(rd);
                    end
                    OpLdar: begin
                        ctrl_o.mux_b_sel   = MuxIrImm;
                        ctrl_o.arf_reg_sel = ArfSelAr;
                        ctrl_o.arf_fun_sel = FunLoad;
                    end
                    OpHalt: begin
                        state_d_o = StHalt;
                    end
                    default: begin
                        state_d_o = StFetchL;
                    end
                endcase
            end

            StExec2: begin
                ctrl_o.rf_out_a_sel = rd;
                ctrl_o.rf_out_b_sel = rs1;
                ctrl_o.mux_c_sel    = MuxCRfA;
                ctrl_o.alu_fun_sel  = AluAdd;
                ctrl_o.mux_a_sel    = MuxAluOut;
                ctrl_o.rf_fun_sel   = FunLoad;
                ctrl_o.rf_reg_sel   = rf_sel(rd);
                state_d_o           = StFetchL;
            end

            StHalt: begin
                ctrl_o.halted = 1'b1;
                state_d_o     = StHalt;
            end

            default: begin
                state_d_o = StInit;
            end
        endcase

        // Reset forces a quiet datapath regardless of the current state.
        if (reset_i) begin
            ctrl_o = ctrl_idle();
        end
    end

endmodule

// File: rtl/control_unit.sv
// Multi-cycle control unit top: state register plus decoder driving the ALUSystem selects.
module control_unit
    import cu_pkg::*;
(
    input  logic        Clock,
    input  logic        Reset,
    input  logic [15:0] IROut,
    input  logic [3:0]  ALUOutFlag,
    output logic [1:0]  RF_OutASel,
    output logic [1:0]  RF_OutBSel,
    output logic [1:0]  RF_FunSel,
    output logic [3:0]  RF_RegSel,
    output logic [3:0]  ALU_FunSel,
    output logic [1:0]  ARF_OutCSel,
    output logic [1:0]  ARF_OutDSel,
    output logic [1:0]  ARF_FunSel,
    output logic [2:0]  ARF_RegSel,
    output logic        IR_LH,
    output logic        IR_Enable,
    output logic [1:0]  IR_Funsel,
    output logic        Mem_WR,
    output logic        Mem_CS,
    output logic [1:0]  MuxASel,
    output logic [1:0]  MuxBSel,
    output logic        MuxCSel,
    output logic        Halted
);

    state_e state_q;
    state_e state_d;
    ctrl_t  ctrl;

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q <= StInit;
        end else begin
            state_q <= state_d;
        end
    end

    cu_decode u_decode (
        .state_i   (state_q),
        .reset_i   (Reset),
        .ir_i      (IROut),
        .flag_i    (ALUOutFlag),
        .ctrl_o    (ctrl),
        .state_d_o (state_d)
    );

    assign RF_OutASel  = ctrl.rf_out_a_sel;
    assign RF_OutBSel  = ctrl.rf_out_b_sel;
    assign RF_FunSel   = ctrl.rf_fun_sel;
    assign RF_RegSel   = ctrl.rf_reg_sel;
    assign ALU_FunSel  = ctrl.alu_fun_sel;
    assign ARF_OutCSel = ctrl.arf_out_c_sel;
    assign ARF_OutDSel = ctrl.arf_out_d_sel;
    assign ARF_FunSel  = ctrl.arf_fun_sel;
    assign ARF_RegSel  = ctrl.arf_reg_sel;
    assign IR_LH       = ctrl.ir_lh;
    assign IR_Enable   = ctrl.ir_enable;
    assign IR_Funsel   = ctrl.ir_funsel;
    assign Mem_WR      = ctrl.mem_wr;
    assign Mem_CS      = ctrl.mem_cs;
    assign MuxASel     = ctrl.mux_a_sel;
    assign MuxBSel     = ctrl.mux_b_sel;
    assign MuxCSel     = ctrl.mux_c_sel;
    assign Halted      = ctrl.halted;

endmodule

// File: tb/tb_control_unit.sv
// Bench for control_unit: directed vector table, hand-written reset/halt sequences, random vs model.
module tb_control_unit;

    logic        Clock;
    logic        Reset;
    logic [15:0] IROut;
    logic [3:0]  ALUOutFlag;
    logic [1:0]  RF_OutASel, RF_OutBSel, RF_FunSel;
    logic [3:0]  RF_RegSel, ALU_FunSel;
    logic [1:0]  ARF_OutCSel, ARF_OutDSel, ARF_FunSel;
    logic [2:0]  ARF_RegSel;
    logic        IR_LH, IR_Enable;
    logic [1:0]  IR_Funsel;
    logic        Mem_WR, Mem_CS;
    logic [1:0]  MuxASel, MuxBSel;
    logic        MuxCSel, Halted;

    int errors = 0;
    int checks = 0;

    control_unit dut (
        .Clock(Clock), .Reset(Reset), .IROut(IROut), .ALUOutFlag(ALUOutFlag),
        .RF_OutASel(RF_OutASel), .RF_OutBSel(RF_OutBSel), .RF_FunSel(RF_FunSel),
        .RF_RegSel(RF_RegSel), .ALU_FunSel(ALU_FunSel), .ARF_OutCSel(ARF_OutCSel),
        .ARF_OutDSel(ARF_OutDSel), .ARF_FunSel(ARF_FunSel), .ARF_RegSel(ARF_RegSel),
        .IR_LH(IR_LH), .IR_Enable(IR_Enable), .IR_Funsel(IR_Funsel), .Mem_WR(Mem_WR),
        .Mem_CS(Mem_CS), .MuxASel(MuxASel), .MuxBSel(MuxBSel), .MuxCSel(MuxCSel),
        .Halted(Halted)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    typedef struct packed {
        logic [1:0] a_sel, b_sel, rf_fun;
        logic [3:0] rf_reg, alu;
        logic [1:0] arf_c, arf_d, arf_fun;
        logic [2:0] arf_reg;
        logic       ir_lh, ir_en;
        logic [1:0] ir_fun;
        logic       wr, cs;
        logic [1:0] mux_a, mux_b;
        logic       mux_c, halted;
    } outs_t;

    typedef struct packed {
        logic [3:0] rf_reg;
        logic [1:0] rf_fun;
        logic [2:0] arf_reg;
        logic [1:0] arf_fun;
        logic [3:0] alu;
        logic [1:0] mux_a, mux_b;
        logic       cs, wr, ir_en, ir_lh, halted;
    } sub_t;

    typedef struct {
        logic        rst;
        logic [15:0] ir;
        logic [3:0]  fl;
        sub_t        exp;
    } vec_t;

    outs_t got;
    sub_t  got_sub;
    assign got = {RF_OutASel, RF_OutBSel, RF_FunSel, RF_RegSel, ALU_FunSel, ARF_OutCSel,
                  ARF_OutDSel, ARF_FunSel, ARF_RegSel, IR_LH, IR_Enable, IR_Funsel, Mem_WR,
                  Mem_CS, MuxASel, MuxBSel, MuxCSel, Halted};
    assign got_sub = {RF_RegSel, RF_FunSel, ARF_RegSel, ARF_FunSel, ALU_FunSel, MuxASel,
                      MuxBSel, Mem_CS, Mem_WR, IR_Enable, IR_LH, Halted};

    // Phase of the instruction cycle as the model sees it.
    localparam int PhInit = 0, PhFetchL = 1, PhFetchH = 2, PhExec = 3, PhExec2 = 4, PhHalt = 5;

    logic [3:0] alu_tab [6];
    initial alu_tab = '{4'b0000, 4'b0111, 4'b1000, 4'b0100, 4'b0110, 4'b0010};

    function automatic outs_t model_out(int ph, logic rst, logic [15:0] ir, logic [3:0] fl);
        outs_t o;
        int op;
        logic [1:0] rd, rs1, rs2;
        logic [3:0] oh;
        o = '0;
        o.cs = 1'b1;
        op = int'(ir[15:12]);
        rd = ir[11:10];
        rs1 = ir[9:8];
        rs2 = ir[7:6];
        oh = 4'b0001 << rd;
        if (rst) return o;
        if (ph == PhInit) begin
            o.rf_reg = 4'b1111; o.arf_reg = 3'b111; o.rf_fun = 2'b11; o.arf_fun = 2'b11;
        end else if (ph == PhFetchL || ph == PhFetchH) begin
            o.arf_d = 2'b00; o.cs = 1'b0; o.ir_en = 1'b1; o.ir_lh = (ph == PhFetchH);
            o.ir_fun = 2'b10; o.arf_reg = 3'b100; o.arf_fun = 2'b01;
        end else if (ph == PhHalt) begin
            o.halted = 1'b1;
        end else if (ph == PhExec2) begin
            o.a_sel = rd; o.b_sel = rs1; o.alu = 4'b0100; o.mux_a = 2'b00;
            o.rf_fun = 2'b10; o.rf_reg = oh;
        end else begin
            if (op == 0) o.mux_a = 2'b10;
            if (op == 1 || op == 14) begin
                o.arf_d = 2'b10; o.cs = 1'b0; o.mux_a = 2'b01;
            end
            if (op >= 3 && op <= 8) begin
                o.a_sel = rs1; o.b_sel = rs2; o.alu = alu_tab[op-3];
            end
            if (op <= 1 || (op >= 3 && op <= 8) || op == 14) begin
                o.rf_fun = 2'b10; o.rf_reg = oh;
            end
            if (op == 2) begin
                o.arf_d = 2'b10; o.a_sel = rd; o.cs = 1'b0; o.wr = 1'b1;
            end
            if (op == 9 || (op == 10 && !fl[3])) begin
                o.mux_b = 2'b10; o.arf_reg = 3'b100; o.arf_fun = 2'b10;
            end
            if (op == 11 || op == 12) begin
                o.rf_fun = (op == 11) ? 2'b01 : 2'b00; o.rf_reg = oh;
            end
            if (op == 13) begin
                o.mux_b = 2'b10; o.arf_reg = 3'b010; o.arf_fun = 2'b10;
            end
        end
        return o;
    endfunction

    function automatic int model_next(int ph, logic rst, logic [15:0] ir);
        if (rst) return PhInit;
        case (ph)
            PhInit:   return PhFetchL;
            PhFetchL: return PhFetchH;
            PhFetchH: return PhExec;
            PhExec:   return (ir[15:12] == 4'hE) ? PhExec2 :
                             (ir[15:12] == 4'hF) ? PhHalt : PhFetchL;
            PhHalt:   return PhHalt;
            default:  return PhFetchL;
        endcase
    endfunction

    function automatic sub_t es(logic [3:0] rr, logic [1:0] rf, logic [2:0] ar, logic [1:0] af,
                                logic [3:0] alu, logic [1:0] ma, logic [1:0] mb, logic cs,
                                logic wr, logic en, logic lh, logic h);
        return {rr, rf, ar, af, alu, ma, mb, cs, wr, en, lh, h};
    endfunction

    function automatic vec_t mk(logic rst, logic [15:0] ir, logic [3:0] fl, sub_t e);
        vec_t v;
        v.rst = rst; v.ir = ir; v.fl = fl; v.exp = e;
        return v;
    endfunction

    task automatic check(input string name, input logic [35:0] g, input logic [35:0] e);
        checks++;
        if (g !== e) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, g, e, $time);
        end
    endtask

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    vec_t tbl[$];
    sub_t s_idle, s_init, s_fl, s_fh;
    outs_t exp_o;
    int mph;
    logic rr;
    logic [15:0] ri;
    logic [3:0] rf;

    initial begin
        Reset = 1'b1;
        IROut = 16'h0000;
        ALUOutFlag = 4'h0;

        s_idle = es(4'h0, 2'd0, 3'd0, 2'd0, 4'h0, 2'd0, 2'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        s_init = es(4'hF, 2'd3, 3'd7, 2'd3, 4'h0, 2'd0, 2'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        s_fl   = es(4'h0, 2'd0, 3'd4, 2'd1, 4'h0, 2'd0, 2'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        s_fh   = es(4'h0, 2'd0, 3'd4, 2'd1, 4'h0, 2'd0, 2'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);

        tbl.push_back(mk(1'b1, 16'h0000, 4'h0, s_idle));
        tbl.push_back(mk(1'b1, 16'h0000, 4'h0, s_idle));
        tbl.push_back(mk(1'b0, 16'h0000, 4'h0, s_init));
        tbl.push_back(mk(1'b0, 16'h0000, 4'h0, s_fl));
        tbl.push_back(mk(1'b0, 16'h0000, 4'h0, s_fh));
        tbl.push_back(mk(1'b0, 16'h0C5A, 4'h0,
            es(4'h8, 2'd2, 3'd0, 2'd0, 4'h0, 2'd2, 2'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0)));
        tbl.push_back(mk(1'b0, 16'h0000, 4'h0, s_fl));
        tbl.push_back(mk(1'b0, 16'h0000, 4'h0, s_fh));
        tbl.push_back(mk(1'b0, 16'hA020, 4'h8, s_idle));
        tbl.push_back(mk(1'b0, 16'h0000, 4'h0, s_fl));
        tbl.push_back(mk(1'b0, 16'h0000, 4'h0, s_fh));
        tbl.push_back(mk(1'b0, 16'hA020, 4'h0,
            es(4'h0, 2'd0, 3'd4, 2'd2, 4'h0, 2'd0, 2'd2, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0)));
        tbl.push_back(mk(1'b0, 16'h0000, 4'h0, s_fl));
        tbl.push_back(mk(1'b0, 16'h0000, 4'h0, s_fh));
        tbl.push_back(mk(1'b0, 16'h2900, 4'h0,
            es(4'h0, 2'd0, 3'd0, 2'd0, 4'h0, 2'd0, 2'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0)));
        tbl.push_back(mk(1'b0, 16'h0000, 4'h0, s_fl));
        tbl.push_back(mk(1'b0, 16'h0000, 4'h0, s_fh));
        tbl.push_back(mk(1'b0, 16'hB400, 4'h0,
            es(4'h2, 2'd1, 3'd0, 2'd0, 4'h0, 2'd0, 2'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0)));
        tbl.push_back(mk(1'b0, 16'h0000, 4'h0, s_fl));
        tbl.push_back(mk(1'b0, 16'h0000, 4'h0, s_fh));
        tbl.push_back(mk(1'b0, 16'hE400, 4'h0,
            es(4'h2, 2'd2, 3'd0, 2'd0, 4'h0, 2'd1, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0)));
        tbl.push_back(mk(1'b0, 16'hE400, 4'h0,
            es(4'h2, 2'd2, 3'd0, 2'd0, 4'h4, 2'd0, 2'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0)));
        tbl.push_back(mk(1'b0, 16'h0000, 4'h0, s_fl));
        tbl.push_back(mk(1'b0, 16'h0000, 4'h0, s_fh));
        tbl.push_back(mk(1'b0, 16'hF000, 4'h0, s_idle));
        tbl.push_back(mk(1'b0, 16'hF000, 4'h0,
            es(4'h0, 2'd0, 3'd0, 2'd0, 4'h0, 2'd0, 2'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1)));

        foreach (tbl[i]) begin
            Reset = tbl[i].rst;
            IROut = tbl[i].ir;
            ALUOutFlag = tbl[i].fl;
            #1;
            check($sformatf("table_row%0d", i), 36'(got_sub), 36'(tbl[i].exp));
            tick();
        end

        // HALT holds regardless of the instruction bus.
        for (int k = 0; k < 20; k++) begin
            IROut = 16'($urandom);
            #1;
            check("halt_hold", {34'd0, Halted, Mem_CS}, 36'h3);
            tick();
        end
        Reset = 1'b1;
        #1;
        check("halt_reset_idle", {31'd0, RF_RegSel, Mem_CS}, 36'h1);
        tick();
        Reset = 1'b0;
        #1;
        check("halt_reset_init", {31'd0, Halted, RF_RegSel}, 36'h0F);
        tick();

        // Reset during FETCH_H.
        #1;
        check("fl_after_init", {35'd0, IR_Enable}, 36'h1);
        tick();
        Reset = 1'b1;
        #1;
        check("fh_reset_ir_en", {35'd0, IR_Enable}, 36'h0);
        tick();
        Reset = 1'b0;
        #1;
        check("fh_reset_init", {32'd0, RF_RegSel}, 36'hF);
        tick();

        // Reset during EXEC2.
        tick();
        tick();
        IROut = 16'hE400;
        #1;
        check("addm_exec", {33'd0, Mem_CS, MuxASel}, 36'h1);
        tick();
        Reset = 1'b1;
        #1;
        check("exec2_reset_idle", {27'd0, Mem_CS, RF_RegSel, ALU_FunSel}, 36'h100);
        tick();
        Reset = 1'b0;
        #1;
        check("exec2_reset_init", {32'd0, RF_RegSel}, 36'hF);
        tick();

        // Random stimulus against the model; first cycle is a reset to align phases.
        mph = PhInit;
        for (int i = 0; i < 3000; i++) begin
            rr = (i == 0) || ($urandom_range(0, 39) == 0);
            ri = 16'($urandom);
            rf = 4'($urandom);
            Reset = rr;
            IROut = ri;
            ALUOutFlag = rf;
            #1;
            exp_o = model_out(mph, rr, ri, rf);
            check($sformatf("random_c%0d_ph%0d_ir%h", i, mph, ri), 36'(got), 36'(exp_o));
            mph = model_next(mph, rr, ri);
            tick();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
